// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the 5-bit opcode map and the
// fetch-stage state encoding used by fetch_controller and its helpers.
package cpu_pkg;

  localparam int INSTR_W = 9;
  localparam int OP_W    = 5;
  localparam int PC_W    = 16;

  localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LOAD  = 5'b00001;
  localparam logic [OP_W-1:0] OP_STORE = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b00100;
  localparam logic [OP_W-1:0] OP_JMP   = 5'b00101;
  localparam logic [OP_W-1:0] OP_BEQ   = 5'b00110;
  localparam logic [OP_W-1:0] OP_HALT  = 5'b11010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bus: control inputs, the ROM address/data pair and the IF/ID
// register outputs. master = fetch controller, slave = its environment.
interface fetch_controller_if;
  import cpu_pkg::*;

  logic                start;
  logic                stall;
  logic                redirect_valid;
  logic [PC_W-1:0]     redirect_pc;
  logic [PC_W-1:0]     pc;
  logic [INSTR_W-1:0]  rom_instr;
  logic [INSTR_W-1:0]  if_instr;
  logic [PC_W-1:0]     if_pc;
  logic                if_valid;
  logic                busy;
  logic                halted;
  logic [PC_W-1:0]     fetch_count;

  modport master (
    input  start, stall, redirect_valid, redirect_pc, rom_instr,
    output pc, if_instr, if_pc, if_valid, busy, halted, fetch_count
  );

  modport slave (
    output start, stall, redirect_valid, redirect_pc, rom_instr,
    input  pc, if_instr, if_pc, if_valid, busy, halted, fetch_count
  );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating count of accepted fetches; cleared by reset or a new program start.
module fetch_perf_cnt
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            inc,
  output logic [PC_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch stage: drives pc to a combinational ROM and registers the
// IF/ID word. Define FETCH_PERF_CNT_EN to build the accepted-fetch counter.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] START_PC = 16'd1,
  parameter logic [OP_W-1:0] HALT_OP  = 5'b11010
) (
  input  logic              clk,
  input  logic              reset,
  fetch_controller_if.master bus
);

  fetch_state_t        state, next_state;
  logic [PC_W-1:0]     pc_q;
  logic [INSTR_W-1:0]  if_instr_q;
  logic [PC_W-1:0]     if_pc_q;
  logic                if_valid_q;

  logic is_halt;
  logic accept;
  logic take_redirect;
  logic load_start;
  logic clear_valid;

  assign is_halt = (opcode_of(bus.rom_instr) == HALT_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Redirect outranks both stall and a halt word arriving in the same cycle.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    take_redirect = 1'b0;
    load_start    = 1'b0;
    clear_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        clear_valid = 1'b1;
        if (bus.start) begin
          load_start = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.redirect_valid) begin
          take_redirect = 1'b1;
        end else if (!bus.stall) begin
          accept = 1'b1;
          if (is_halt) begin
            next_state = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        clear_valid = !bus.stall;
        if (bus.start) begin
          load_start = 1'b1;
          next_state = ST_FETCH;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= START_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      if (load_start) begin
        pc_q <= START_PC;
      end
      if (take_redirect) begin
        pc_q       <= bus.redirect_pc;
        if_valid_q <= 1'b0;
      end
      if (accept) begin
        if_instr_q <= bus.rom_instr;
        if_pc_q    <= pc_q;
        if_valid_q <= 1'b1;
        if (!is_halt) begin
          pc_q <= pc_q + PC_W'(1);
        end
      end
      if (clear_valid) begin
        if_valid_q <= 1'b0;
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.busy     = (state == ST_FETCH);
  assign bus.halted   = (state == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [PC_W-1:0] perf_count;

  fetch_perf_cnt u_perf_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (load_start),
    .inc   (accept),
    .count (perf_count)
  );

  assign bus.fetch_count = perf_count;
`else
  assign bus.fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus a random
// run, all compared against a cycle-level behavioural model of the fetch stage.
module tb_fetch_controller;

  localparam logic [15:0] START = 16'd1;
  localparam logic [4:0]  HALT  = 5'b11010;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk;
  logic        reset;
  logic        halt_en;
  logic [15:0] halt_addr;
  int          n_cmp;
  int          n_fail;

  int          m_mode;
  logic [15:0] m_pc;
  logic [15:0] m_if_pc;
  logic [15:0] m_count;
  logic [8:0]  m_if_instr;
  logic        m_if_valid;

  fetch_controller_if bus ();

  fetch_controller #(.START_PC(16'd1), .HALT_OP(5'b11010)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ROM contents: a non-halt word derived from the address, except at
  // halt_addr when halt_en is set.
  function automatic logic [8:0] rom_fn(input logic [15:0] a, input logic hen,
                                        input logic [15:0] ha);
    logic [4:0] op;
    if (hen && (a == ha)) return {HALT, 4'h0};
    op = a[4:0] + 5'd3;
    if (op == HALT) op = 5'd0;
    return {op, a[3:0]};
  endfunction

  assign bus.rom_instr = rom_fn(bus.pc, halt_en, halt_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic rst, input logic st, input logic sl,
                            input logic rv, input logic [15:0] rpc);
    logic [8:0] w;
    w = rom_fn(m_pc, halt_en, halt_addr);
    if (rst) begin
      m_mode = M_IDLE; m_pc = START; m_if_instr = '0; m_if_pc = '0;
      m_if_valid = 1'b0; m_count = '0;
    end else if (m_mode == M_RUN) begin
      if (rv) begin
        m_pc = rpc;
        m_if_valid = 1'b0;
      end else if (!sl) begin
        m_if_instr = w;
        m_if_pc    = m_pc;
        m_if_valid = 1'b1;
`ifdef FETCH_PERF_CNT_EN
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
`endif
        if (w[8:4] == HALT) m_mode = M_HALT;
        else m_pc = m_pc + 16'd1;
      end
    end else begin
      if (m_mode == M_IDLE || !sl) m_if_valid = 1'b0;
      if (st) begin
        m_mode = M_RUN; m_pc = START; m_count = '0;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic sl,
                       input logic rv, input logic [15:0] rpc);
    reset = rst;
    bus.start = st;
    bus.stall = sl;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    model_step(rst, st, sl, rv, rpc);
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to(input logic [15:0] target);
    for (int i = 0; i < 40 && m_pc != target; i++) drive(0, 0, 0, 0, 16'd0);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    drive(1, 1, 1, 1, 16'h1234);
    drive(1, 0, 0, 0, 16'h0000);
    n_cmp++; if (bus.pc !== 16'd1) begin n_fail++; $display("[TB] FAIL reset_pc: got %h want 0001", bus.pc); end
    n_cmp++; if (bus.if_instr !== 9'h000) begin n_fail++; $display("[TB] FAIL reset_if_instr: got %h want 000", bus.if_instr); end
    n_cmp++; if (bus.if_pc !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_if_pc: got %h want 0000", bus.if_pc); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_if_valid: got %b want 0", bus.if_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted: got %b want 0", bus.halted); end
    n_cmp++; if (bus.fetch_count !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_count: got %h want 0000", bus.fetch_count); end
  endtask

  task automatic test_linear();
    $display("[TB] test_linear");
    drive(0, 1, 0, 0, 16'd0);
    n_cmp++; if (bus.pc !== 16'd1) begin n_fail++; $display("[TB] FAIL start_pc: got %h want 0001", bus.pc); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL start_if_valid: got %b want 0", bus.if_valid); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL start_busy: got %b want 1", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 2), 0, 0, 16'd0);
      n_cmp++; if (bus.pc !== 16'(i + 2)) begin n_fail++; $display("[TB] FAIL linear_pc: got %h want %h", bus.pc, 16'(i + 2)); end
      n_cmp++; if (bus.if_pc !== 16'(i + 1)) begin n_fail++; $display("[TB] FAIL linear_if_pc: got %h want %h", bus.if_pc, 16'(i + 1)); end
      n_cmp++; if (bus.if_instr !== m_if_instr) begin n_fail++; $display("[TB] FAIL linear_if_instr: got %h want %h", bus.if_instr, m_if_instr); end
      n_cmp++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL linear_if_valid: got %b want 1", bus.if_valid); end
    end
  endtask

  task automatic test_stall();
    logic [15:0] held_pc;
    logic [8:0]  held_instr;
    $display("[TB] test_stall");
    advance_to(16'd5);
    held_pc = m_if_pc;
    held_instr = m_if_instr;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 16'd0);
      n_cmp++; if (bus.pc !== 16'd5) begin n_fail++; $display("[TB] FAIL stall_pc: got %h want 0005", bus.pc); end
      n_cmp++; if (bus.if_pc !== held_pc) begin n_fail++; $display("[TB] FAIL stall_if_pc: got %h want %h", bus.if_pc, held_pc); end
      n_cmp++; if (bus.if_instr !== held_instr) begin n_fail++; $display("[TB] FAIL stall_if_instr: got %h want %h", bus.if_instr, held_instr); end
    end
    drive(0, 0, 0, 0, 16'd0);
    n_cmp++; if (bus.if_pc !== 16'd5) begin n_fail++; $display("[TB] FAIL stall_resume_if_pc: got %h want 0005", bus.if_pc); end
    n_cmp++; if (bus.pc !== 16'd6) begin n_fail++; $display("[TB] FAIL stall_resume_pc: got %h want 0006", bus.pc); end
  endtask

  task automatic test_redirect();
    $display("[TB] test_redirect");
    advance_to(16'd12);
    drive(0, 0, 1, 1, 16'd90);
    n_cmp++; if (bus.pc !== 16'd90) begin n_fail++; $display("[TB] FAIL redirect_pc: got %h want 005a", bus.pc); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL redirect_bubble: got %b want 0", bus.if_valid); end
    drive(0, 0, 0, 0, 16'd0);
    n_cmp++; if (bus.if_pc !== 16'd90) begin n_fail++; $display("[TB] FAIL redirect_if_pc: got %h want 005a", bus.if_pc); end
    n_cmp++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL redirect_if_valid: got %b want 1", bus.if_valid); end
  endtask

  task automatic test_halt();
    $display("[TB] test_halt");
    halt_en = 1'b1;
    halt_addr = 16'd7;
    drive(1, 0, 0, 0, 16'd0);
    drive(0, 1, 0, 0, 16'd0);
    advance_to(16'd7);
    drive(0, 0, 0, 1, 16'd3);
    n_cmp++; if (bus.halted !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL redirect_over_halt_state: got busy=%b halted=%b want busy=1 halted=0", bus.busy, bus.halted); end
    n_cmp++; if (bus.pc !== 16'd3) begin n_fail++; $display("[TB] FAIL redirect_over_halt_pc: got %h want 0003", bus.pc); end
    advance_to(16'd7);
    drive(0, 0, 0, 0, 16'd0);
    n_cmp++; if (bus.if_instr !== 9'h1A0) begin n_fail++; $display("[TB] FAIL halt_if_instr: got %h want 1a0", bus.if_instr); end
    n_cmp++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_if_valid: got %b want 1", bus.if_valid); end
    n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("[TB] FAIL halt_halted: got %b want 1", bus.halted); end
    n_cmp++; if (bus.pc !== 16'd7) begin n_fail++; $display("[TB] FAIL halt_pc: got %h want 0007", bus.pc); end
    drive(0, 0, 0, 1, 16'd50);
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL halted_if_valid: got %b want 0", bus.if_valid); end
    n_cmp++; if (bus.pc !== 16'd7) begin n_fail++; $display("[TB] FAIL halted_pc_hold: got %h want 0007", bus.pc); end
    drive(0, 1, 0, 0, 16'd0);
    n_cmp++; if (bus.pc !== 16'd1) begin n_fail++; $display("[TB] FAIL restart_pc: got %h want 0001", bus.pc); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_busy: got %b want 1", bus.busy); end
    halt_en = 1'b0;
  endtask

  task automatic test_wrap_and_abort();
    $display("[TB] test_wrap_and_abort");
    drive(0, 0, 0, 1, 16'hFFFF);
    drive(0, 0, 0, 0, 16'd0);
    n_cmp++; if (bus.pc !== 16'h0000) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h want 0000", bus.pc); end
    n_cmp++; if (bus.if_pc !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL wrap_if_pc: got %h want ffff", bus.if_pc); end
    drive(0, 0, 0, 1, 16'd38);
    advance_to(16'd40);
    n_cmp++; if (bus.pc !== 16'd40) begin n_fail++; $display("[TB] FAIL abort_setup_pc: got %h want 0028", bus.pc); end
    drive(1, 1, 1, 1, 16'd77);
    n_cmp++; if (bus.pc !== 16'd1) begin n_fail++; $display("[TB] FAIL abort_pc: got %h want 0001", bus.pc); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.halted !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_state: got busy=%b halted=%b want 0 0", bus.busy, bus.halted); end
    n_cmp++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_if_valid: got %b want 0", bus.if_valid); end
    n_cmp++; if (bus.fetch_count !== 16'h0000) begin n_fail++; $display("[TB] FAIL abort_count: got %h want 0000", bus.fetch_count); end
  endtask

  task automatic test_count();
    logic [15:0] exp_count;
`ifdef FETCH_PERF_CNT_EN
    exp_count = 16'd10;
`else
    exp_count = 16'd0;
`endif
    $display("[TB] test_count");
    drive(1, 0, 0, 0, 16'd0);
    drive(0, 1, 0, 0, 16'd0);
    for (int i = 0; i < 13; i++) begin
      drive(0, 0, (i == 3 || i == 7), (i == 5), 16'd200);
      n_cmp++; if (bus.fetch_count !== m_count) begin n_fail++; $display("[TB] FAIL count_step: got %h want %h", bus.fetch_count, m_count); end
    end
    n_cmp++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("[TB] FAIL count_total: got %0d want %0d", bus.fetch_count, exp_count); end
  endtask

  task automatic test_random();
    logic rst, st, sl, rv;
    logic [15:0] rpc;
    $display("[TB] test_random");
    halt_en = 1'b1;
    halt_addr = 16'($urandom_range(2, 9));
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) halt_addr = 16'($urandom_range(2, 9));
      rst = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 7) == 0);
      sl  = ($urandom_range(0, 2) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = 16'($urandom_range(0, 12));
      drive(rst, st, sl, rv, rpc);
      n_cmp++; if (bus.pc !== m_pc) begin n_fail++; $display("[TB] FAIL rand_pc cyc %0d: got %h want %h", i, bus.pc, m_pc); end
      n_cmp++; if (bus.if_instr !== m_if_instr) begin n_fail++; $display("[TB] FAIL rand_if_instr cyc %0d: got %h want %h", i, bus.if_instr, m_if_instr); end
      n_cmp++; if (bus.if_pc !== m_if_pc) begin n_fail++; $display("[TB] FAIL rand_if_pc cyc %0d: got %h want %h", i, bus.if_pc, m_if_pc); end
      n_cmp++; if (bus.if_valid !== m_if_valid) begin n_fail++; $display("[TB] FAIL rand_if_valid cyc %0d: got %b want %b", i, bus.if_valid, m_if_valid); end
      n_cmp++; if (bus.busy !== (m_mode == M_RUN)) begin n_fail++; $display("[TB] FAIL rand_busy cyc %0d: got %b want %b", i, bus.busy, (m_mode == M_RUN)); end
      n_cmp++; if (bus.halted !== (m_mode == M_HALT)) begin n_fail++; $display("[TB] FAIL rand_halted cyc %0d: got %b want %b", i, bus.halted, (m_mode == M_HALT)); end
      n_cmp++; if (bus.fetch_count !== m_count) begin n_fail++; $display("[TB] FAIL rand_count cyc %0d: got %h want %h", i, bus.fetch_count, m_count); end
    end
    halt_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    halt_en = 1'b0;
    halt_addr = 16'd0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'd0;
    m_mode = M_IDLE;
    m_pc = START;
    m_if_pc = '0;
    m_if_instr = '0;
    m_if_valid = 1'b0;
    m_count = '0;
    test_reset();
    test_linear();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap_and_abort();
    test_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter START_PC, default 16'd1, the first fetch address after reset or start.
REQ-002 SHALL have parameter HALT_OP, default 5'b11010, the opcode field value that ends fetch.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a pulse that begins fetch from START_PC.
REQ-006 SHALL have port stall, input, 1, a downstream hold request from the decode stage.
REQ-007 SHALL have port redirect_valid, input, 1, a branch or jump taken from a later stage.
REQ-008 SHALL have port redirect_pc, input, 16, the target address qualified by redirect_valid.
REQ-009 SHALL have port pc, output, 16, the address driven to the combinational instruction ROM.
REQ-010 SHALL have port rom_instr, input, 9, the ROM word for pc: [8:4] opcode, [3:0] operand.
REQ-011 SHALL have port if_instr, output, 9, the registered IF/ID instruction.
REQ-012 SHALL have port if_pc, output, 16, the address of if_instr.
REQ-013 SHALL have port if_valid, output, 1, which qualifies if_instr and if_pc.
REQ-014 SHALL have port busy, output, 1, high in state FETCH.
REQ-015 SHALL have port halted, output, 1, high in state HALTED.
REQ-016 SHALL have port fetch_count, output, 16, the count of accepted fetches.

Function
REQ-017 SHALL implement three states (IDLE, FETCH, HALTED) with these transitions:
- IDLE to FETCH on start.
- FETCH to HALTED on an accepted halt fetch.
- HALTED to FETCH on start, with pc reloaded to START_PC.
REQ-018 SHALL ignore start while in FETCH.
REQ-019 SHALL, in IDLE and HALTED, hold pc and ignore redirect_valid.
REQ-020 SHALL treat a FETCH cycle with no stall and no redirect_valid as an accepted fetch, with these updates:
- if_instr <= rom_instr
- if_pc <= pc
- if_valid <= 1
- pc <= pc+1
REQ-021 SHALL give a latency of one cycle: the word at pc appears on if_instr on the edge after pc is presented.
REQ-022 SHALL increment pc modulo 2^16, so 16'hFFFF is followed by 16'h0000.
REQ-023 SHALL, in FETCH with stall=1 and no redirect_valid, hold pc, if_instr, if_pc and if_valid unchanged.
REQ-024 SHALL, on redirect_valid in FETCH, set pc <= redirect_pc and if_valid <= 0, giving one bubble.
REQ-025 SHALL give redirect_valid priority over stall.
REQ-026 SHALL, on an accepted fetch whose rom_instr[8:4]==HALT_OP:
- latch the halt word with if_valid=1;
- keep pc unchanged (no increment);
- enter HALTED.
REQ-027 SHALL give redirect_valid priority over a halt opcode in the same cycle, so the halt is not latched and the state stays FETCH.
REQ-028 SHALL, in HALTED, clear if_valid on the first cycle with stall=0 and keep it 0 thereafter.
REQ-029 SHALL clear if_valid in IDLE.
REQ-030 SHALL drive busy = (state==FETCH) and halted = (state==HALTED) combinationally from state.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, set:
- state = IDLE
- pc = START_PC
- if_instr = 9'h000
- if_pc = 16'h0000
- if_valid = 0
- fetch_count = 0
REQ-032 SHALL give reset priority over start, stall and redirect_valid, and SHALL abort fetch mid-program with no partial update.

Configuration
REQ-033 SHALL, with FETCH_PERF_CNT_EN defined, have fetch_count:
- increment on every accepted fetch, including a halt fetch;
- saturate at 16'hFFFF;
- clear on reset and on an accepted start.
REQ-034 SHALL, without FETCH_PERF_CNT_EN, tie fetch_count to 16'h0000 and instantiate no counter logic.

Structure
REQ-035 SHALL take the following from shared package cpu_pkg:
- INSTR_W=9, OP_W=5, PC_W=16;
- the 5-bit opcode constants, including halt=5'b11010;
- the fetch state enum.
REQ-036 SHALL place the saturating counter in sub-module fetch_perf_cnt, instantiated only under FETCH_PERF_CNT_EN.

Verification
REQ-037 SHALL be verified by a bench covering, at minimum, these directed scenarios:
- Reset then start, ROM linear from address 1 -> pc steps 1,2,3; if_pc 1,2 one cycle later; if_valid rises one cycle after start.
- stall=1 for 3 cycles at pc=5 -> pc stays 5; if_instr and if_pc frozen; on release, fetch resumes at 5.
- redirect_valid with redirect_pc=16'd90 while stall=1 at pc=12 -> next pc=90, if_valid=0 for one cycle, then if_pc=90.
- rom_instr=9'b11010_0000 at pc=7 -> if_instr=9'h1A0 with if_valid=1, halted=1, pc stays 7, then if_valid=0; start -> pc=1, busy=1.
- pc=16'hFFFF with accepted fetch -> pc=16'h0000; reset asserted mid-fetch at pc=40 -> pc=1, IDLE, if_valid=0, fetch_count=0.
- With FETCH_PERF_CNT_EN: 10 accepted fetches, 2 stalls and 1 redirect -> fetch_count=10; without the macro, fetch_count=0 throughout.
